// File: rtl/adc_frame_pkg.sv
// Shared types for the ADC frame packer: FSM states and the 128-bit header layout.
package adc_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DONE
  } state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  // Field order fixes the bit offsets: magic [127:112], ch_id [111:104], seq [103:88],
  // len [87:72], cnt [71:40], reserved [39:0].
  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  ch_id;
    logic [15:0] seq;
    logic [15:0] len;
    logic [31:0] cnt;
    logic [39:0] rsvd;
  } hdr_t;

  function automatic logic [127:0] build_header(input logic [7:0]  ch,
                                                input logic [15:0] seq,
                                                input logic [15:0] len,
                                                input logic [31:0] cnt);
    hdr_t h;
    h.magic = HDR_MAGIC;
    h.ch_id = ch;
    h.seq   = seq;
    h.len   = len;
    h.cnt   = cnt;
    h.rsvd  = '0;
    return h;
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample input and packet output stream of the frame packer.
// master: capture block + readout consumer side; slave: the packer.
interface adc_frame_packer_if;
  logic [127:0] sample_data;
  logic         sample_strobe;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (
    output sample_data, sample_strobe, m_ready,
    input  m_data, m_valid
  );

  modport slave (
    input  sample_data, sample_strobe, m_ready,
    output m_data, m_valid
  );
endinterface

// File: rtl/adc_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module adc_frame_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;

  // A write is refused on the registered full flag even if a read frees a slot this cycle.
  assign wr_ok = wr_en_i && !full_q;
  assign rd_ok = rd_en_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_ok && !rd_ok)      cnt_d = cnt_q + CNT_ONE;
    else if (!wr_ok && rd_ok) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/adc_frame_packer.sv
// Frames 128-bit ADC capture words into headered packets, buffers them in a FWFT FIFO
// and signals count_equal once the programmed number of words has been captured.
module adc_frame_packer #(
  parameter logic [7:0]  CH_ID      = 8'd0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture_en,
  input  logic [15:0]              frame_len,
  input  logic [31:0]              total_words,
  adc_frame_packer_if.slave        bus,
  output logic                     count_equal,
  output logic                     overflow,
  output logic [15:0]              frame_seq
);
  import adc_frame_pkg::*;

  state_e       state_q, state_d;
  logic         cap_en_q;
  logic [15:0]  flen_q, flen_d;
  logic [31:0]  total_q, total_d;
  logic [31:0]  word_cnt_q, word_cnt_d, word_cnt_inc;
  logic [15:0]  fwc_q, fwc_d;
  logic [15:0]  seq_q, seq_d;
  logic         ovf_q, ovf_d;
  logic         pend_valid_q, pend_valid_d;
  logic [127:0] pend_data_q, pend_data_d;
  logic         last_word;

  logic         fifo_wr;
  logic [127:0] fifo_wdata;
  logic         fifo_full, fifo_empty;

  assign word_cnt_inc = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 32'd1;
  assign last_word    = (total_q != '0) && (word_cnt_inc == total_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cap_en_q     <= 1'b0;
      flen_q       <= 16'd1;
      total_q      <= '0;
      word_cnt_q   <= '0;
      fwc_q        <= '0;
      seq_q        <= '0;
      ovf_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cap_en_q     <= capture_en;
      flen_q       <= flen_d;
      total_q      <= total_d;
      word_cnt_q   <= word_cnt_d;
      fwc_q        <= fwc_d;
      seq_q        <= seq_d;
      ovf_q        <= ovf_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flen_d       = flen_q;
    total_d      = total_q;
    word_cnt_d   = word_cnt_q;
    fwc_d        = fwc_q;
    seq_d        = seq_q;
    ovf_d        = ovf_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    fifo_wr      = 1'b0;
    fifo_wdata   = pend_data_q;

    if (!capture_en) begin
      state_d      = ST_IDLE;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cap_en_q) begin
            flen_d       = (frame_len == '0) ? 16'd1 : frame_len;
            total_d      = total_words;
            word_cnt_d   = '0;
            fwc_d        = '0;
            seq_d        = '0;
            ovf_d        = 1'b0;
            pend_valid_d = 1'b0;
            state_d      = ST_HEADER;
          end
        end

        ST_HEADER: begin
          // fwc_q here counts strobes taken while stalled, so subtracting it gives
          // the index of the frame's first payload word.
          fifo_wr    = !fifo_full;
          fifo_wdata = build_header(CH_ID, seq_q, flen_q, word_cnt_q - {16'd0, fwc_q});
          if (!fifo_full) seq_d = seq_q + 16'd1;
          if (bus.sample_strobe) begin
            word_cnt_d = word_cnt_inc;
            fwc_d      = fwc_q + 16'd1;
            if (pend_valid_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_valid_d = 1'b1;
              pend_data_d  = bus.sample_data;
            end
          end
          if (bus.sample_strobe && last_word) state_d = ST_DONE;
          else if (!fifo_full)                state_d = ST_PAYLOAD;
        end

        ST_PAYLOAD: begin
          fifo_wr    = (pend_valid_q || bus.sample_strobe) && !fifo_full;
          fifo_wdata = pend_valid_q ? pend_data_q : bus.sample_data;
          if (pend_valid_q && !fifo_full) pend_valid_d = 1'b0;
          if (bus.sample_strobe) begin
            word_cnt_d = word_cnt_inc;
            fwc_d      = fwc_q + 16'd1;
            if (fifo_full) begin
              ovf_d = 1'b1;
            end else if (pend_valid_q) begin
              // pending word takes the write port; the new word queues behind it
              pend_valid_d = 1'b1;
              pend_data_d  = bus.sample_data;
            end
          end
          if (bus.sample_strobe && last_word) begin
            state_d = ST_DONE;
          end else if ((fwc_d >= flen_q) && !pend_valid_d) begin
            state_d = ST_HEADER;
            fwc_d   = '0;
          end
        end

        ST_DONE: begin
          fifo_wr = pend_valid_q && !fifo_full;
          if (fifo_wr) pend_valid_d = 1'b0;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  adc_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (128)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (bus.m_ready),
    .rd_data_o (bus.m_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.m_valid = !fifo_empty;
  assign count_equal = (state_q == ST_DONE);
  assign overflow    = ovf_q;
  assign frame_seq   = seq_q;

endmodule
